// File: rtl/sa3_tile_sequencer.sv
// sa3_tile_sequencer: loads a 4x4 activation tile and a 3x3 filter from a byte
// stream, enables systolic_array_3_by_3 for a fixed window, captures its four
// results on done_sa3 (or on timeout) and streams them out.
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  input byte handshake, in_data: a11..a44 then b11..b33
//   a_flat, b_flat     tile and filter presented to the array
//   active_sa3         array enable, high for ACTIVE_CYCLES cycles
//   done_sa3, c11..c22 array completion pulse and results
//   out_valid/out_ready result byte handshake, out_data: c11,c12,c21,c22
//   busy               high unless idle in LOAD with nothing loaded
//   err                sticky done timeout flag
module sa3_tile_sequencer #(
   parameter int DW            = 8,
   parameter int ACTIVE_CYCLES = 17,
   parameter int DONE_TIMEOUT  = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [16*DW-1:0] a_flat,
   output logic [9*DW-1:0] b_flat,
   output logic            active_sa3,
   input  logic            done_sa3,
   input  logic [DW-1:0]   c11,
   input  logic [DW-1:0]   c12,
   input  logic [DW-1:0]   c21,
   input  logic [DW-1:0]   c22,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic            busy,
   output logic            err
);
   localparam int RW = $clog2(ACTIVE_CYCLES + 1);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   typedef enum logic [1:0] {LOAD, RUN, WAIT, SEND} state_t;
   state_t          state_q;
   logic [4:0]      load_cnt_q;
   logic [RW-1:0]   run_cnt_q;
   logic [TW-1:0]   wait_cnt_q;
   logic [1:0]      send_cnt_q;
   logic [DW-1:0]   mem_q [25];
   logic [DW-1:0]   res_q [4];
   logic            done_seen_q, active_q, out_valid_q, err_q;
   // slots 0..15 hold the activations, 16..24 the weights
   for (genvar k = 0; k < 16; k++) begin : g_a
      assign a_flat[DW*k +: DW] = mem_q[k];
   end
   for (genvar k = 0; k < 9; k++) begin : g_b
      assign b_flat[DW*k +: DW] = mem_q[16+k];
   end
   assign in_ready   = rst && state_q == LOAD;
   assign busy       = !(state_q == LOAD && load_cnt_q == 5'd0);
   assign active_sa3 = active_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_valid_q ? res_q[send_cnt_q] : '0;
   assign err        = err_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD;
         load_cnt_q  <= '0;
         run_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         send_cnt_q  <= '0;
         for (int k = 0; k < 25; k++) mem_q[k] <= '0;
         for (int k = 0; k < 4; k++) res_q[k] <= '0;
         done_seen_q <= 1'b0;
         active_q    <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            LOAD: if (in_valid) begin
               mem_q[load_cnt_q] <= in_data;
               if (load_cnt_q == 5'd24) begin
                  load_cnt_q  <= '0;
                  run_cnt_q   <= '0;
                  done_seen_q <= 1'b0;
                  active_q    <= 1'b1;
                  state_q     <= RUN;
               end else begin
                  load_cnt_q <= load_cnt_q + 5'd1;
               end
            end
            RUN: begin
               // an early done is kept, but the enable window always runs out
               if (done_sa3) begin
                  res_q       <= '{c11, c12, c21, c22};
                  done_seen_q <= 1'b1;
               end
               if (run_cnt_q == RW'(ACTIVE_CYCLES - 1)) begin
                  active_q    <= 1'b0;
                  wait_cnt_q  <= '0;
                  send_cnt_q  <= '0;
                  out_valid_q <= done_seen_q || done_sa3;
                  state_q     <= (done_seen_q || done_sa3) ? SEND : WAIT;
               end else begin
                  run_cnt_q <= run_cnt_q + RW'(1);
               end
            end
            WAIT: begin
               // on timeout the current results are sent anyway
               if (done_sa3 || wait_cnt_q == TW'(DONE_TIMEOUT - 1)) begin
                  res_q       <= '{c11, c12, c21, c22};
                  err_q       <= err_q || !done_sa3;
                  send_cnt_q  <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= SEND;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
            end
            SEND: if (out_ready) begin
               if (send_cnt_q == 2'd3) begin
                  send_cnt_q  <= '0;
                  load_cnt_q  <= '0;
                  out_valid_q <= 1'b0;
                  state_q     <= LOAD;
               end else begin
                  send_cnt_q <= send_cnt_q + 2'd1;
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_sa3_tile_sequencer.sv
// tb_sa3_tile_sequencer: randomized bench for sa3_tile_sequencer with a
// transaction-level model of load, enable window, capture and result stream.
module tb_sa3_tile_sequencer;
   localparam int DW  = 8;
   localparam int ACT = 17;
   localparam int TO  = 64;
   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [DW-1:0]   in_data;
   logic [16*DW-1:0] a_flat;
   logic [9*DW-1:0] b_flat;
   logic            active_sa3, done_sa3;
   logic [DW-1:0]   c11, c12, c21, c22;
   logic            out_valid, out_ready;
   logic [DW-1:0]   out_data;
   logic            busy, err;
   int              checks = 0;
   int              failures = 0;
   bit              exp_err = 0;
   logic [DW-1:0]   plan [25] = '{1,2,3,0, 0,1,2,3, 3,0,1,2, 2,3,0,1, 2,0,1, 0,1,2, 1,0,2};
   bit              pat [7] = '{1,0,0,1,0,1,1};
   sa3_tile_sequencer #(.DW(DW), .ACTIVE_CYCLES(ACT), .DONE_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .a_flat(a_flat), .b_flat(b_flat), .active_sa3(active_sa3), .done_sa3(done_sa3),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drive_c(input bit dir);
      c11 = dir ? DW'(15) : DW'($urandom);
      c12 = dir ? DW'(16) : DW'($urandom);
      c21 = dir ? DW'(6)  : DW'($urandom);
      c22 = dir ? DW'(15) : DW'($urandom);
   endtask
   function automatic bit ordy(input int n, input int stall);
      return stall < 0 ? pat[n % 7] : ($urandom_range(99) >= stall);
   endfunction
   // mode 0: no done, 1: done dly cycles after the window, 2: done on window cycle dly
   task automatic tile(input bit dir, input int gap, input int stall, input int mode,
                       input int dly, input int rcyc);
      logic [DW-1:0]    bytes [25];
      logic [DW-1:0]    exp_c [4];
      logic [DW-1:0]    q [$];
      logic [16*DW-1:0] ea;
      logic [9*DW-1:0]  eb;
      logic [DW-1:0]    prev;
      int               idx, n, act, w, erw;
      bit               early, bad_hold, stl;
      exp_c = '{0, 0, 0, 0};
      for (int k = 0; k < 25; k++) bytes[k] = dir ? plan[k] : DW'($urandom);
      for (int k = 0; k < 16; k++) ea[DW*k +: DW] = bytes[k];
      for (int k = 0; k < 9; k++) eb[DW*k +: DW] = bytes[16+k];
      idx = 0; n = 0; early = 0;
      while (idx < 25 && n < 1000) begin
         @(negedge clk); n++;
         in_valid  = $urandom_range(99) >= gap;
         in_data   = in_valid ? bytes[idx] : DW'($urandom);
         done_sa3  = $urandom_range(3) == 0;
         out_ready = $urandom_range(1);
         drive_c(dir);
         #1;
         if (active_sa3 || out_valid) early = 1;
         if (in_valid && in_ready) idx++;
      end
      chk("load_bytes", idx, 25);
      chk("no_early_run", early, 0);
      act = 0; n = 0;
      while (n < 100) begin
         @(negedge clk); n++;
         in_valid  = 0;
         done_sa3  = mode == 2 && act == dly;
         out_ready = ordy(0, stall);
         drive_c(dir);
         if (rcyc >= 0 && act == rcyc) begin
            rst = 0;
            #1;
            chk("rst_active", active_sa3, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_a_flat", a_flat, 0);
            chk("rst_b_flat", b_flat, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            @(negedge clk);
            rst = 1; done_sa3 = 0; exp_err = 0;
            return;
         end
         #1;
         if (!active_sa3) break;
         if (act == 0) begin
            chk("a_flat", a_flat, ea);
            chk("b_flat", b_flat, eb);
            chk("in_ready_run", in_ready, 0);
            chk("busy_run", busy, 1);
         end
         act++;
         if (done_sa3) exp_c = '{c11, c12, c21, c22};
      end
      chk("active_len", act, ACT);
      erw = -1; w = 0;
      while (w < 200) begin
         if (err && erw < 0) erw = w;
         if (out_valid) break;
         if ((mode == 0 && w == TO - 1) || (mode == 1 && done_sa3)) exp_c = '{c11, c12, c21, c22};
         @(negedge clk); w++;
         done_sa3  = mode == 1 && w == dly;
         out_ready = ordy(0, stall);
         drive_c(dir);
         #1;
      end
      if (mode == 2) chk("send_after_run", w, 0);
      else if (mode == 1) chk("send_after_done", w, dly + 1);
      else chk("send_after_timeout", w, TO);
      if (mode == 0) begin
         if (!exp_err) chk("err_latency", erw, TO);
         exp_err = 1;
      end
      chk("err_flag", err, exp_err);
      chk("ab_stable", {a_flat, b_flat}, {ea, eb});
      n = 0; bad_hold = 0; stl = 0; prev = '0;
      while (n < 200) begin
         if (!out_valid) break;
         if (stl && out_data !== prev) bad_hold = 1;
         if (out_ready) q.push_back(out_data);
         stl = !out_ready; prev = out_data;
         @(negedge clk); n++;
         out_ready = ordy(n, stall);
         done_sa3  = $urandom_range(1);
         drive_c(dir);
         #1;
      end
      chk("out_count", q.size(), 4);
      for (int i = 0; i < 4; i++) chk("out_value", i < q.size() ? q[i] : 'x, exp_c[i]);
      chk("out_hold", bad_hold, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      done_sa3 = 0;
   endtask
   initial begin
      int mode;
      rst = 0; in_valid = 0; in_data = '0; done_sa3 = 0; out_ready = 0;
      c11 = '0; c12 = '0; c21 = '0; c22 = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_a_flat", a_flat, 0);
      chk("reset_b_flat", b_flat, 0);
      chk("reset_active", active_sa3, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_err", err, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      rst = 1;
      #1;
      chk("release_in_ready", in_ready, 1);
      tile(1, 0, 0, 1, 3, -1);
      tile(1, 0, -1, 1, 3, -1);
      tile(0, 40, 0, 1, 5, -1);
      tile(0, 30, 30, 0, 0, -1);
      tile(0, 20, 20, 1, 2, -1);
      tile(0, 0, 0, 1, 2, 8);
      tile(0, 20, 20, 1, 4, -1);
      tile(0, 0, 30, 2, 16, -1);
      tile(0, 10, 30, 2, 0, -1);
      tile(0, 10, 10, 1, TO - 1, -1);
      for (int t = 0; t < 8; t++) begin
         mode = $urandom_range(2, 1);
         tile(0, $urandom_range(50), $urandom_range(60), mode,
              mode == 2 ? $urandom_range(16) : $urandom_range(20, 1), -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sa3_tile_sequencer.md
Name: sa3_tile_sequencer

Overview:
- Front-end sequencer that drives systolic_array_3_by_3 and collects its results.
- Accepts a serial byte stream over valid/ready: a 4x4 activation tile, then a 3x3 filter.
- Presents both to the array and holds active_sa3 high for a fixed window.
- Captures c11..c22 when done_sa3 arrives, then streams the four results out serially over valid/ready.

Parameters:
DW, 8, data width of every activation, weight and result byte
ACTIVE_CYCLES, 17, number of consecutive cycles active_sa3 is held high
DONE_TIMEOUT, 64, cycles after the active window to wait for done_sa3 before flagging an error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  sequencer can accept an input byte
in_data  in  DW  input byte: 16 activations row-major (a11,a12..a44), then 9 weights row-major (b11..b33)
a_flat  out  16*DW  activation tile; a_flat[DW*k +: DW] = a(r,c), k=4*(r-1)+(c-1)
b_flat  out  9*DW  filter; b_flat[DW*k +: DW] = b(r,c), k=3*(r-1)+(c-1)
active_sa3  out  1  array enable
done_sa3  in  1  array completion pulse
c11,c12,c21,c22  in  DW each  array results
out_valid  out  1  result byte valid
out_ready  in  1  downstream accepts result byte
out_data  out  DW  results in order c11,c12,c21,c22
busy  out  1  high in any state other than LOAD with count 0
err  out  1  sticky done timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, all counters 0.
  - a_flat, b_flat, captured results and out_data all 0.
  - active_sa3=0, out_valid=0, err=0, in_ready=0 while rst is low.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes in_data to slot load_cnt (0..15 into a, 16..24 into b) and increments load_cnt.
  - The write of slot 24 moves to RUN on the next edge; in_ready=0 from then on.
  - a_flat and b_flat change only during LOAD and stay stable through RUN/WAIT.
- RUN:
  - active_sa3=1 for exactly ACTIVE_CYCLES consecutive cycles, counted by run_cnt.
  - Then goes to WAIT with active_sa3=0.
  - done_sa3 seen during RUN is captured, the window still completes, and WAIT is skipped: next state is SEND.
- WAIT:
  - Waits for done_sa3.
  - On the cycle done_sa3=1, register c11,c12,c21,c22 and go to SEND.
  - If DONE_TIMEOUT cycles elapse with no done: set err=1 (sticky until reset), capture current c values anyway, go to SEND.
- SEND:
  - out_valid=1; out_data = captured result at index send_cnt (0:c11, 1:c12, 2:c21, 3:c22).
  - Advance only on out_valid&out_ready; out_data must hold while out_ready=0.
  - After the 4th handshake: out_valid=0, load_cnt=0, back to LOAD.
- Capture rule: results are registered on the done cycle; later changes on c* do not affect the values sent.
- done_sa3 in LOAD or SEND is ignored.
- Arithmetic: pure storage, no arithmetic. Widths are exact; counters sized for 25, ACTIVE_CYCLES and DONE_TIMEOUT without wrap.
- Back-to-back: the first byte of the next tile is accepted on the cycle after the 4th output handshake.
- in_valid toggling mid-load: gaps allowed; the count is preserved.
- Reset mid-operation: immediately returns to the reset state and discards any partial tile or pending results.

Test Plan:
1. Load a = [1,2,3,0, 0,1,2,3, 3,0,1,2, 2,3,0,1], b = [2,0,1, 0,1,2, 1,0,2], model pulses done 3 cycles after RUN ends with c = 15,16,6,15 -> a_flat/b_flat match, active_sa3 high exactly 17 cycles, outputs 15,16,6,15 in order, err=0.
2. Same tile, out_ready toggling 1,0,0,1,0,1,1 -> exactly 4 handshakes, out_data stable while stalled, values 15,16,6,15.
3. in_valid gaps (1,0,1,1,0,...) during load -> all 25 bytes land in the correct slots; RUN starts only after byte 25.
4. Model never asserts done -> err=1 exactly DONE_TIMEOUT cycles after active_sa3 falls, 4 bytes still emitted, next tile loads normally with err still 1.
5. Drop rst low mid-RUN (cycle 8) -> active_sa3, out_valid and err go 0 at once; a_flat = 0; a fresh tile then completes correctly.
6. done_sa3 pulsed during RUN cycle 16 -> active window still 17 cycles, SEND follows directly and emits the values captured at that pulse.
